// File: rtl/bpm_tempo_tracker.sv
// Energy-based beat detector with history-mean threshold, refractory gating and a serial
// restoring divider that turns beat intervals into BPM. Optional macro: BPM_SMOOTH_EN.
module bpm_tempo_tracker #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SAMPLE_RATE  = 30720,
  parameter int unsigned WINDOW_SIZE  = 512,
  parameter int unsigned HIST_DEPTH   = 8,
  parameter int unsigned THRESH_NUM   = 3,
  parameter int unsigned THRESH_SHIFT = 1,
  parameter int unsigned MIN_BPM      = 60,
  parameter int unsigned MAX_BPM      = 200,
  parameter int unsigned ENERGY_WIDTH = 40,
  parameter int unsigned BPM_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] audio_sample,
  input  logic                           sample_valid,
  output logic                           beat_detected,
  output logic [BPM_WIDTH-1:0]           bpm_val,
  output logic                           bpm_valid,
  output logic                           busy
);

  localparam int unsigned Hb          = $clog2(HIST_DEPTH);
  localparam int unsigned Ew          = ENERGY_WIDTH;
  localparam int unsigned Sw          = ENERGY_WIDTH + Hb;
  localparam int unsigned Sqw         = 2 * SAMPLE_WIDTH;
  localparam int unsigned Wcw         = $clog2(WINDOW_SIZE);
  localparam int unsigned Num         = 60 * SAMPLE_RATE;
  localparam int unsigned Refract     = Num / MAX_BPM;
  localparam int unsigned MaxInterval = Num / MIN_BPM;
  localparam int unsigned MaxInt      = MaxInterval + 1;
  localparam int unsigned Cw          = $clog2(MaxInt + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} div_state_e;

  logic [Wcw-1:0]  win_cnt_q;
  logic [Ew-1:0]   acc_q;
  logic [Ew-1:0]   hist_q [HIST_DEPTH];
  logic [Hb-1:0]   wr_ptr_q;
  logic [Sw-1:0]   sum_q;
  logic [Hb:0]     fill_q;
  logic [Cw-1:0]   ivl_q;
  logic            seen_q;
  logic            beat_q;

  logic signed [Sqw-1:0] samp_ext;
  logic [Sqw-1:0]  sq;
  logic [Ew:0]     acc_sum;
  logic [Ew-1:0]   e_next;
  logic [Sw-1:0]   mean;
  logic [Sw+7:0]   thr;
  logic [Cw-1:0]   ivl_inc;
  logic            boundary;
  logic            beat_ok;
  logic            start_div;

  always_comb begin
    samp_ext  = Sqw'(audio_sample);
    sq        = samp_ext * samp_ext;
    acc_sum   = {1'b0, acc_q} + (Ew + 1)'(sq);
    e_next    = acc_sum[Ew] ? '1 : acc_sum[Ew-1:0];
    mean      = sum_q >> Hb;
    thr       = ((Sw + 8)'(mean) * (Sw + 8)'(THRESH_NUM)) >> THRESH_SHIFT;
    ivl_inc   = (ivl_q == Cw'(MaxInt)) ? ivl_q : ivl_q + 1'b1;
    boundary  = sample_valid && (win_cnt_q == Wcw'(WINDOW_SIZE - 1));
    beat_ok   = boundary && (fill_q == (Hb + 1)'(HIST_DEPTH)) && (mean != '0) &&
                ((Sw + 8)'(e_next) > thr) && (ivl_inc >= Cw'(Refract));
    start_div = beat_ok && seen_q && (ivl_inc <= Cw'(MaxInterval));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt_q <= '0;
      acc_q     <= '0;
      wr_ptr_q  <= '0;
      sum_q     <= '0;
      fill_q    <= '0;
      ivl_q     <= '0;
      seen_q    <= 1'b0;
      beat_q    <= 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      beat_q <= beat_ok;
      if (sample_valid) begin
        ivl_q <= beat_ok ? '0 : ivl_inc;
        if (boundary) begin
          win_cnt_q        <= '0;
          acc_q            <= '0;
          // hist_q[wr_ptr_q] is the oldest entry (zero while still filling)
          hist_q[wr_ptr_q] <= e_next;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
          sum_q            <= sum_q + Sw'(e_next) - Sw'(hist_q[wr_ptr_q]);
          if (fill_q != (Hb + 1)'(HIST_DEPTH)) fill_q <= fill_q + 1'b1;
        end else begin
          win_cnt_q <= win_cnt_q + 1'b1;
          acc_q     <= e_next;
        end
      end
      if (beat_ok) seen_q <= 1'b1;
    end
  end

  // Divider: three-process FSM plus shift datapath
  div_state_e state_q, state_d;
  logic [4:0]  step_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic        publish;
  logic [31:0] clamped;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_div) state_d = StRun;
      StRun: begin
        if (beat_ok)              state_d = start_div ? StRun : StIdle;
        else if (step_q == 5'd31) state_d = StDone;
      end
      StDone:                     state_d = start_div ? StRun : StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q == StRun);
    publish = (state_q == StDone);
    rem_sh  = {rem_q, quo_q[31]};
    rem_ge  = rem_sh >= {1'b0, dvs_q};
    clamped = (quo_q < MIN_BPM) ? MIN_BPM : ((quo_q > MAX_BPM) ? MAX_BPM : quo_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start_div) begin
      step_q <= '0;
      quo_q  <= 32'(Num);
      rem_q  <= '0;
      dvs_q  <= 32'(ivl_inc);
    end else if (busy) begin
      step_q <= step_q + 1'b1;
      quo_q  <= {quo_q[30:0], rem_ge};
      rem_q  <= rem_ge ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
    end
  end

  logic [BPM_WIDTH-1:0] bpm_q;
  logic                 bpm_valid_q;
  logic [BPM_WIDTH-1:0] bpm_new;

`ifdef BPM_SMOOTH_EN
  logic                 loaded_q;
  logic [BPM_WIDTH+1:0] blend;

  always_comb begin
    blend   = ((BPM_WIDTH + 2)'(bpm_q) * (BPM_WIDTH + 2)'(3) +
               (BPM_WIDTH + 2)'(clamped)) >> 2;
    bpm_new = loaded_q ? blend[BPM_WIDTH-1:0] : BPM_WIDTH'(clamped);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       loaded_q <= 1'b0;
    else if (publish) loaded_q <= 1'b1;
  end
`else
  always_comb bpm_new = BPM_WIDTH'(clamped);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
    end else begin
      bpm_valid_q <= publish;
      if (publish) bpm_q <= bpm_new;
    end
  end

  assign beat_detected = beat_q;
  assign bpm_val       = bpm_q;
  assign bpm_valid     = bpm_valid_q;

endmodule

// File: tb/tb_bpm_tempo_tracker.sv
// Directed bench: 1/32-scaled rate and window (960 Hz, 16 samples) so window counts
// match the full-size tempo scenarios; 57600/480 = 120 BPM, 57600/576 = 100 BPM.
module tb_bpm_tempo_tracker;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] audio_sample = '0;
  logic               sample_valid = 1'b0;
  logic               beat_detected;
  logic [15:0]        bpm_val;
  logic               bpm_valid;
  logic               busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int valid_cnt = 0;
  int beat_cyc = 0;
  int valid_cyc = 0;
  int busy_at_beat = 0;
  int last_pub = 0;

  bpm_tempo_tracker #(
    .SAMPLE_RATE (960),
    .WINDOW_SIZE (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .audio_sample  (audio_sample),
    .sample_valid  (sample_valid),
    .beat_detected (beat_detected),
    .bpm_val       (bpm_val),
    .bpm_valid     (bpm_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (beat_detected) begin
      beat_cnt     <= beat_cnt + 1;
      beat_cyc     <= cyc;
      busy_at_beat <= int'(busy);
    end
    if (bpm_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
      last_pub  <= int'(bpm_val);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Send n windows of 16 alternating +/-amp samples, one sample every 4 clocks.
  task automatic run(input int n, input int amp);
    for (int w = 0; w < n; w++) begin
      for (int s = 0; s < 16; s++) begin
        audio_sample = 16'(s[0] ? -amp : amp);
        sample_valid = 1'b1;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic settle();
    repeat (40) @(posedge clk);
    #1;
  endtask

  int exp_smooth;

  initial begin
`ifdef BPM_SMOOTH_EN
    exp_smooth = 115;
`else
    exp_smooth = 100;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_beat", int'(beat_detected), 0);
    check("rst_bpm", int'(bpm_val), 0);
    check("rst_valid", int'(bpm_valid), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run(1, 8000);
    run(19, 100);
    check("warmup_no_beat", beat_cnt, 0);

    run(1, 8000);                                 // window 20: first beat, no division
    settle();
    check("first_beat", beat_cnt, 1);
    check("first_no_valid", valid_cnt, 0);
    check("first_bpm", int'(bpm_val), 0);

    run(29, 100);
    run(1, 8000);                                 // window 50: 30 windows later
    settle();
    check("steady_beat", beat_cnt, 2);
    check("steady_valid", valid_cnt, 1);
    check("steady_bpm", int'(bpm_val), 120);
    check("steady_pub", last_pub, 120);
    check("latency", valid_cyc - beat_cyc, 33);
    check("busy_with_beat", busy_at_beat, 1);

    run(1, 100);
    run(1, 8000);                                 // window 52: inside refractory
    settle();
    check("refract_no_beat", beat_cnt, 2);

    run(27, 100);
    run(1, 8000);                                 // window 80: 30 after window 50
    settle();
    check("refract_beat", beat_cnt, 3);
    check("refract_valid", valid_cnt, 2);
    check("refract_bpm", int'(bpm_val), 120);

    run(35, 100);
    run(1, 8000);                                 // window 116: 36 windows
    settle();
    check("slow_beat", beat_cnt, 4);
    check("slow_valid", valid_cnt, 3);
    check("slow_bpm", int'(bpm_val), exp_smooth);

    run(69, 100);
    run(1, 8000);                                 // window 186: 70 windows, out of range
    settle();
    check("range_beat", beat_cnt, 5);
    check("range_no_valid", valid_cnt, 3);
    check("range_bpm", int'(bpm_val), exp_smooth);

    run(29, 100);
    run(1, 8000);                                 // window 216: division starts
    repeat (5) @(posedge clk);
    #1;
    check("mid_beat", beat_cnt, 6);
    check("mid_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("abort_beat", int'(beat_detected), 0);
    check("abort_bpm", int'(bpm_val), 0);
    check("abort_valid", int'(bpm_valid), 0);
    check("abort_busy", int'(busy), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    settle();
    check("abort_no_valid", valid_cnt, 3);
    check("abort_bpm_after", int'(bpm_val), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bpm_tempo_tracker.md
# bpm_tempo_tracker

Parametrised tempo tracker that replaces the single-window energy beat detector in the audio analysis path. It sits after the sample decimator and before the display/LED logic. It accumulates per-window energy, compares each window against a ring-buffer mean of the last `HIST_DEPTH` windows, and applies a refractory period. It measures beat intervals in samples rather than clocks and computes BPM with a multi-cycle restoring divider, with range checking and a valid strobe.

## Interface
- `SAMPLE_WIDTH`, 16: signed audio sample width.
- `SAMPLE_RATE`, 30720: sample rate in Hz; fixes the BPM numerator `60*SAMPLE_RATE`.
- `WINDOW_SIZE`, 512: samples per energy window, ≥2.
- `HIST_DEPTH`, 8: windows in the history ring buffer; power of two, ≥2.
- `THRESH_NUM`, 3: threshold multiplier numerator, 8-bit unsigned.
- `THRESH_SHIFT`, 1: threshold divisor exponent. Default threshold is avg×1.5.
- `MIN_BPM`, 60: lowest BPM reported.
- `MAX_BPM`, 200: highest BPM reported; also sets the refractory period.
- `ENERGY_WIDTH`, 40: window energy accumulator width.
- `BPM_WIDTH`, 16: BPM output width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `audio_sample`  in  SAMPLE_WIDTH  signed sample, qualified by `sample_valid`.
- `sample_valid`  in  1  one-cycle sample strobe.
- `beat_detected`  out  1  one-cycle pulse per accepted beat.
- `bpm_val`  out  BPM_WIDTH  latest tempo estimate.
- `bpm_valid`  out  1  one-cycle pulse when `bpm_val` updates.
- `busy`  out  1  divider running.

## Operation
- **Energy.** On each `sample_valid`, add `audio_sample²` (unsigned, 2·SAMPLE_WIDTH bits) to the window accumulator. The accumulator saturates at all-ones.
- **Window boundary.** The boundary is the `sample_valid` that completes sample `WINDOW_SIZE-1`. At the boundary:
  - Compare the completed energy E against the current history mean A, where A = running sum >> log2(HIST_DEPTH).
  - Push E into the ring buffer and update the running sum as sum + E − oldest, using ENERGY_WIDTH+log2(HIST_DEPTH) bits.
  - Clear the accumulator. The boundary sample's own energy is included in E, not in the next window.
- **Warm-up.** No beat is declared until HIST_DEPTH windows have been pushed since reset. The fill counter saturates.
- **Beat condition.** All of the following must hold:
  - warm-up is complete;
  - A ≠ 0;
  - E > (A·THRESH_NUM) >> THRESH_SHIFT, computed at full width with no truncation;
  - the samples since the last accepted beat are ≥ REFRACT = 60·SAMPLE_RATE/(MAX_BPM·1) (integer, elaboration-time).
- **Beats that fail refractory** are ignored completely: no pulse, and the interval counter is not reset.
- **Interval counter.** Counts `sample_valid` events and saturates at MAXINT = 60·SAMPLE_RATE/MIN_BPM + 1.
- **On each accepted beat:**
  - Latch the interval and reset the counter to 0.
  - If this is the first beat since reset, or interval > 60·SAMPLE_RATE/MIN_BPM, no division is started.
  - Otherwise start the divider with 60·SAMPLE_RATE / interval.
- **Divider.** Restoring, 32-bit dividend, one quotient bit per cycle, 32 cycles. The result is clamped to [MIN_BPM, MAX_BPM].
- **Beat during division.** The running division is abandoned and restarted with the new interval. Only the restarted result is published.

## Timing
- **Reset values:** `beat_detected`=0, `bpm_val`=0, `bpm_valid`=0, `busy`=0. The accumulator, ring buffer, sum, fill counter, interval counter and first-beat flag all clear.
- **`beat_detected`** is registered and high for exactly the one cycle following the boundary `sample_valid` edge.
- **Divider latency.** `busy` rises in the same cycle as `beat_detected` and is high for 32 cycles. `bpm_val` updates and `bpm_valid` pulses on the cycle after `busy` falls, i.e. 33 cycles after `beat_detected`.
- **Sample during division.** A `sample_valid` that coincides with a divider cycle is processed normally. The energy path and the divider are independent.
- **Reset mid-division** aborts the division without emitting `bpm_valid`.

## Configuration
- **`BPM_SMOOTH_EN` defined:** on publish, `bpm_val` ← (3·`bpm_val` + new) >> 2. The first publish after reset loads `new` directly.
- **`BPM_SMOOTH_EN` undefined:** `bpm_val` ← new (clamped quotient) on every publish.

## Test plan
All scenarios use the defaults: WINDOW_SIZE 512, SAMPLE_RATE 30720, HIST_DEPTH 8. "Quiet" means ±100 alternating; "burst" means a full window at ±8000. Samples are spaced every 4 clocks.

- **Reset:** assert reset mid-stream with a division in flight → all outputs 0 next cycle; no `bpm_valid` afterwards.
- **Warm-up:** burst in window 0, then quiet → no `beat_detected` in windows 0–7.
- **Steady tempo:** after warm-up, a burst every 30 windows (15360 samples) → `beat_detected` each burst. From the second beat on, `bpm_valid` comes 33 cycles later with `bpm_val`=120.
- **Refractory:** bursts 2 windows apart (1024 samples < REFRACT 9216) → second burst gives no pulse; the next burst 30 windows after the first still gives 120.
- **Range:** bursts 70 windows apart (35840 > 30720) → `beat_detected` pulses, no `bpm_valid`, `bpm_val` unchanged.
- **Smoothing (`BPM_SMOOTH_EN`):** intervals of 30 then 36 windows → `bpm_val` 120, then 115. Without the macro: 120, then 100.
